// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised LSB-first UART transmitter fed over a valid/ready handshake.
// Define UART_TX_PARITY_EN to add the parity_odd port and a parity bit after the data bits.
module uart_tx_param #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int DATA_W      = 8,
    parameter int DIV_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [2:0]        baud_set,
    input  logic              stop2,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_odd,
`endif
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(CLK_FREQ_HZ / 9600);
    localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(CLK_FREQ_HZ / 19200);
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(CLK_FREQ_HZ / 38400);
    localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(CLK_FREQ_HZ / 57600);
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(CLK_FREQ_HZ / 115200);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd1:    return DIV_19200;
            3'd2:    return DIV_38400;
            3'd3:    return DIV_57600;
            3'd4:    return DIV_115200;
            default: return DIV_9600;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              stop2_q, stop2_d;
    logic              stop_second_q, stop_second_d;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              ready_q;
    logic              busy_q;
    logic              accept;
    logic              bit_end;

    assign accept   = tx_valid && ready_q;
    assign bit_end  = (cnt_q == div_q - 1'b1);

    assign uart_tx  = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

    // NOTE: every variable written here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        div_d         = div_q;
        data_d        = data_q;
        idx_d         = idx_q;
        stop2_d       = stop2_q;
        stop_second_d = stop_second_q;
`ifdef UART_TX_PARITY_EN
        par_d         = par_q;
`endif
        tx_d          = 1'b1;
        done_d        = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    div_d   = baud_div(baud_set);
                    data_d  = tx_data;
                    stop2_d = stop2;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^tx_data) ^ parity_odd;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d       = ST_PARITY;
`else
                        state_d       = ST_STOP;
`endif
                        stop_second_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d       = ST_STOP;
                    stop_second_d = 1'b0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_second_q) begin
                        stop_second_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so uart_tx never glitches.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase

        done_d = (state_d == ST_STOP) && (cnt_d == div_d - 1'b1) &&
                 (stop_second_d || !stop2_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            div_q         <= '0;
            // NOTE: the word/config holding registers are reset too, so nothing on the
            // line can ever depend on X left over from power-up.
            data_q        <= '0;
            idx_q         <= '0;
            stop2_q       <= 1'b0;
            stop_second_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q         <= 1'b0;
`endif
            tx_q          <= 1'b1;
            done_q        <= 1'b0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            data_q        <= data_d;
            idx_q         <= idx_d;
            stop2_q       <= stop2_d;
            stop_second_q <= stop_second_d;
`ifdef UART_TX_PARITY_EN
            par_q         <= par_d;
`endif
            tx_q          <= tx_d;
            done_q        <= done_d;
            ready_q       <= (state_d == ST_IDLE);
            busy_q        <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: a line monitor decodes every frame cycle by cycle
// and compares it with the words queued when they were handed to the transmitter.
module tb_uart_tx_param;

    localparam int CLK_FREQ_HZ = 5_000_000;
    localparam int DATA_W      = 8;
    localparam int DIV_W       = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS    = 1;
`else
    localparam int PAR_BITS    = 0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              stop2;
        int                div;
        logic              odd;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [2:0]        baud_set = 3'd0;
    logic              stop2 = 1'b0;
    logic              parity_odd = 1'b0;
    logic              uart_tx;
    logic              tx_busy;
    logic              tx_done;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   frames_ok = 0;
    int   frames_aborted = 0;
    int   frame_no = 0;
    int   done_total = 0;
    int   spurious_done = 0;
    int   gap = 0;
    int   last_gap = 0;

    uart_tx_param #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .DATA_W     (DATA_W),
        .DIV_W      (DIV_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .baud_set  (baud_set),
        .stop2     (stop2),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d, wanted %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_div(input logic [2:0] b);
        case (b)
            3'd1:    return CLK_FREQ_HZ / 19200;
            3'd2:    return CLK_FREQ_HZ / 38400;
            3'd3:    return CLK_FREQ_HZ / 57600;
            3'd4:    return CLK_FREQ_HZ / 115200;
            default: return CLK_FREQ_HZ / 9600;
        endcase
    endfunction

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_total++;
    end

    // Walks one frame sample by sample; returns early if reset cuts it short.
    task automatic run_frame(input exp_t e, output logic aborted);
        int   nbits, len, mism, pos, done_hits, done_pos, busy_low;
        logic lvl;
        nbits     = DATA_W + 2 + PAR_BITS;
        pos       = 0;
        done_hits = 0;
        done_pos  = -1;
        busy_low  = 0;
        aborted   = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)                lvl = 1'b0;
            else if (b <= DATA_W)      lvl = e.data[b-1];
            else if (b == nbits - 1)   lvl = 1'b1;
            else                       lvl = (^e.data) ^ e.odd;
            len  = (b == nbits - 1 && e.stop2) ? 2 * e.div : e.div;
            mism = 0;
            for (int s = 0; s < len; s++) begin
                if (pos != 0) @(negedge clk);
                if (!reset_n) begin
                    aborted = 1'b1;
                    return;
                end
                if (uart_tx !== lvl) mism++;
                if (tx_done === 1'b1) begin
                    done_hits++;
                    done_pos = pos;
                end
                if (tx_busy !== 1'b1) busy_low++;
                pos++;
            end
            check($sformatf("frame%0d bit%0d cycles off-level", frame_no, b), mism, 0);
        end
        check($sformatf("frame%0d tx_done pulses", frame_no), done_hits, 1);
        check($sformatf("frame%0d tx_done position", frame_no), done_pos, pos - 1);
        check($sformatf("frame%0d busy-low cycles", frame_no), busy_low, 0);
    endtask

    initial begin : monitor
        exp_t e;
        logic aborted;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                gap = 0;
            end else if (uart_tx === 1'b0) begin
                last_gap = gap;
                gap = 0;
                if (sb.size() == 0) begin
                    check("unexpected frame start", 1, 0);
                end else begin
                    e = sb.pop_front();
                    run_frame(e, aborted);
                    if (aborted) frames_aborted++;
                    else frames_ok++;
                    frame_no++;
                end
            end else begin
                gap++;
                if (tx_done === 1'b1) spurious_done++;
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("tx_ready within budget", (tx_ready === 1'b1), 1);
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [2:0] b,
                        input logic s2, input logic odd);
        exp_t e;
        wait_ready();
        tx_data    = d;
        baud_set   = b;
        stop2      = s2;
        parity_odd = odd;
        tx_valid   = 1'b1;
        e.data  = d;
        e.stop2 = s2;
        e.div   = exp_div(b);
        e.odd   = odd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tx_valid   = 1'b0;
        tx_data    = DATA_W'($urandom);
        baud_set   = 3'($urandom);
        stop2      = ~s2;
        parity_odd = ~odd;
    endtask

    task automatic wait_frames(input int target);
        int guard = 0;
        while (frames_ok < target && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        check("frames completed within budget", frames_ok, target);
    endtask

    initial begin : stimulus
        int done_before;
        int ready_viol;
        int guard;

        // Reset state
        #12;
        check("reset uart_tx", uart_tx, 1);
        check("reset tx_ready", tx_ready, 1);
        check("reset tx_busy", tx_busy, 0);
        check("reset tx_done", tx_done, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // 0x55 at the fastest rate, one stop bit
        send(8'h55, 3'd4, 1'b0, 1'b0);
        wait_frames(1);

        // Out-of-table selector falls back to 9600; baud_set moves mid-frame
        send(8'h81, 3'd7, 1'b0, 1'b0);
        repeat (700) @(negedge clk);
        baud_set = 3'd4;
        wait_frames(2);
        send(8'h3E, 3'd0, 1'b0, 1'b0);
        wait_frames(3);

        // Two stop bits, then a second word queued back-to-back
        send(8'hA3, 3'd4, 1'b1, 1'b0);
        send(8'h5C, 3'd4, 1'b0, 1'b0);
        wait_frames(5);
        check("back-to-back idle gap after 2-stop frame", last_gap, 1);

        // Other rates, including a truncated divisor
        send(8'hF0, 3'd3, 1'b1, 1'b0);
        send(8'h0F, 3'd2, 1'b0, 1'b0);
        wait_frames(7);
        check("back-to-back idle gap after 1-stop frame", last_gap, 1);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 3'd4, 1'b0, 1'b0);
        send(8'h07, 3'd4, 1'b0, 1'b1);
        send(8'hB4, 3'd4, 1'b1, 1'b1);
        wait_frames(10);
`endif

        // Reset in the middle of data bit 3
        send(8'h96, 3'd4, 1'b0, 1'b0);
        repeat (4 * exp_div(3'd4) + 20) @(negedge clk);
        done_before = done_total;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("abort uart_tx", uart_tx, 1);
        check("abort tx_ready", tx_ready, 1);
        check("abort tx_busy", tx_busy, 0);
        check("abort tx_done", tx_done, 0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (2 * exp_div(3'd4)) @(negedge clk);
        check("no tx_done after abort", done_total, done_before);
        check("aborted frame count", frames_aborted, 1);
        send(8'h3C, 3'd4, 1'b0, 1'b0);
        wait_frames(8 + 3 * PAR_BITS);

        // tx_valid held while busy with tx_data churning
        wait_ready();
        tx_data  = 8'hC6;
        baud_set = 3'd4;
        stop2    = 1'b0;
        tx_valid = 1'b1;
        begin
            exp_t e;
            e.data  = 8'hC6;
            e.stop2 = 1'b0;
            e.div   = exp_div(3'd4);
            e.odd   = parity_odd;
            sb.push_back(e);
        end
        @(posedge clk);
        ready_viol = 0;
        guard = 0;
        @(negedge clk);
        while (tx_done !== 1'b1 && guard < 20000) begin
            if (tx_ready !== 1'b0) ready_viol++;
            tx_data  = DATA_W'($urandom);
            baud_set = 3'($urandom);
            @(negedge clk);
            guard++;
        end
        check("tx_done seen while valid held", tx_done, 1);
        check("tx_ready during tx_done cycle", tx_ready, 0);
        tx_valid = 1'b0;
        check("tx_ready high cycles while busy", ready_viol, 0);
        @(negedge clk);
        check("tx_ready back after tx_done", tx_ready, 1);
        wait_frames(9 + 3 * PAR_BITS);
        repeat (3 * exp_div(3'd4)) @(negedge clk);

        check("scoreboard drained", sb.size(), 0);
        check("tx_done outside frames", spurious_done, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
